// File: rtl/main_byte_host_pkg.sv
// Shared definitions for the byte-stream host bridge in front of the main FrodoKEM core.
// Command codes mirror the main core's command set; only the width and null code matter here.
package main_byte_host_pkg;

    localparam int MainCMD_SIZE = 4;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_NONE = '0;

    localparam int CMD_FLAG   = 7;
    localparam int WORD_BYTES = 8;

    typedef enum logic [1:0] {
        RX_HDR,
        RX_CMD_ISSUE,
        RX_COLLECT,
        RX_WORD_ISSUE
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    function automatic logic is_last_byte(input logic [2:0] idx);
        return idx == 3'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/main_byte_host_ser.sv
// TX serializer: accepts a 64-bit word and emits it as eight bytes, most significant first.
module word_to_bytes_ser
    import main_byte_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] i_word,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready
);

    tx_state_t   r_state;
    logic [63:0] r_sreg;
    logic [2:0]  r_tx_idx;
    logic        r_byte_valid;

    assign o_word_ready = (r_state == TX_IDLE);
    assign o_byte       = r_sreg[63:56];
    assign o_byte_valid = r_byte_valid;

    // Shifting out all eight bytes leaves the register zero, so o_byte idles at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= TX_IDLE;
            r_sreg       <= '0;
            r_tx_idx     <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (i_word_valid) begin
                        r_sreg       <= i_word;
                        r_tx_idx     <= '0;
                        r_byte_valid <= 1'b1;
                        r_state      <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (i_byte_ready) begin
                        r_sreg <= {r_sreg[55:0], 8'h00};
                        if (is_last_byte(r_tx_idx)) begin
                            r_byte_valid <= 1'b0;
                            r_state      <= TX_IDLE;
                        end else begin
                            r_tx_idx <= r_tx_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/main_byte_host.sv
// Byte-link host for main: frames on b_in become commands or 64-bit words, main's output words become bytes.
module main_byte_host
    import main_byte_host_pkg::*;
#(
    parameter int CMD_SIZE = MainCMD_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          b_in,
    input  logic                b_in_isReady,
    output logic                b_in_canReceive,
    output logic [7:0]          b_out,
    output logic                b_out_isReady,
    input  logic                b_out_canReceive,
    output logic [CMD_SIZE-1:0] cmd,
    output logic                cmd_isReady,
    input  logic                cmd_canReceive,
    output logic [63:0]         in,
    output logic                in_isReady,
    input  logic                in_canReceive,
    input  logic [63:0]         out,
    input  logic                out_isReady,
    output logic                out_canReceive
);

    rx_state_t           r_rx_state;
    logic [CMD_SIZE-1:0] r_cmd;
    logic                r_cmd_isReady;
    logic [63:0]         r_in;
    logic                r_in_isReady;
    logic [55:0]         r_shift;
    logic [2:0]          r_byte_idx;
    logic [6:0]          r_words_left;

    assign b_in_canReceive = (r_rx_state == RX_HDR) || (r_rx_state == RX_COLLECT);
    assign cmd             = r_cmd;
    assign cmd_isReady     = r_cmd_isReady;
    assign in              = r_in;
    assign in_isReady      = r_in_isReady;

    // Frame FSM; words are packed big-endian by arrival, first byte lands in [63:56].
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state    <= RX_HDR;
            r_cmd         <= '0;
            r_cmd_isReady <= 1'b0;
            r_in          <= '0;
            r_in_isReady  <= 1'b0;
            r_shift       <= '0;
            r_byte_idx    <= '0;
            r_words_left  <= '0;
        end else begin
            case (r_rx_state)
                RX_HDR: begin
                    if (b_in_isReady) begin
                        if (b_in[CMD_FLAG]) begin
                            if (b_in[CMD_SIZE-1:0] != CMD_SIZE'(MainCMD_NONE)) begin
                                r_cmd         <= b_in[CMD_SIZE-1:0];
                                r_cmd_isReady <= 1'b1;
                                r_rx_state    <= RX_CMD_ISSUE;
                            end
                        end else begin
                            r_words_left <= b_in[CMD_FLAG-1:0];
                            r_byte_idx   <= '0;
                            r_rx_state   <= RX_COLLECT;
                        end
                    end
                end
                RX_CMD_ISSUE: begin
                    if (cmd_canReceive) begin
                        r_cmd         <= '0;
                        r_cmd_isReady <= 1'b0;
                        r_rx_state    <= RX_HDR;
                    end
                end
                RX_COLLECT: begin
                    if (b_in_isReady) begin
                        r_shift <= {r_shift[47:0], b_in};
                        if (is_last_byte(r_byte_idx)) begin
                            r_in         <= {r_shift, b_in};
                            r_in_isReady <= 1'b1;
                            r_rx_state   <= RX_WORD_ISSUE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end
                RX_WORD_ISSUE: begin
                    if (in_canReceive) begin
                        r_in         <= '0;
                        r_in_isReady <= 1'b0;
                        if (r_words_left == '0) begin
                            r_rx_state <= RX_HDR;
                        end else begin
                            r_words_left <= r_words_left - 7'd1;
                            r_byte_idx   <= '0;
                            r_rx_state   <= RX_COLLECT;
                        end
                    end
                end
                default: r_rx_state <= RX_HDR;
            endcase
        end
    end

    word_to_bytes_ser u_ser (
        .clk          (clk),
        .rst          (rst),
        .i_word       (out),
        .i_word_valid (out_isReady),
        .o_word_ready (out_canReceive),
        .o_byte       (b_out),
        .o_byte_valid (b_out_isReady),
        .i_byte_ready (b_out_canReceive)
    );

endmodule

// File: tb/tb_main_byte_host.sv
// Directed bench for main_byte_host: scoreboards for cmd, in and b_out transfers checked by immediate assertions.
module tb_main_byte_host;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  b_in = '0;
    logic        b_in_isReady = 1'b0;
    wire         b_in_canReceive;
    wire  [7:0]  b_out;
    wire         b_out_isReady;
    logic        b_out_canReceive = 1'b0;
    wire  [3:0]  cmd;
    wire         cmd_isReady;
    logic        cmd_canReceive = 1'b0;
    wire  [63:0] in;
    wire         in_isReady;
    logic        in_canReceive = 1'b0;
    logic [63:0] out = '0;
    logic        out_isReady = 1'b0;
    wire         out_canReceive;

    int checks = 0;
    int errors = 0;

    logic [3:0]  cmdExp[$];
    logic [63:0] inExp[$];
    logic [7:0]  byteExp[$];

    main_byte_host #(.CMD_SIZE(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .b_in             (b_in),
        .b_in_isReady     (b_in_isReady),
        .b_in_canReceive  (b_in_canReceive),
        .b_out            (b_out),
        .b_out_isReady    (b_out_isReady),
        .b_out_canReceive (b_out_canReceive),
        .cmd              (cmd),
        .cmd_isReady      (cmd_isReady),
        .cmd_canReceive   (cmd_canReceive),
        .in               (in),
        .in_isReady       (in_isReady),
        .in_canReceive    (in_canReceive),
        .out              (out),
        .out_isReady      (out_isReady),
        .out_canReceive   (out_canReceive)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A transfer seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst === 1'b1 && cmd_isReady && cmd_canReceive) begin
            checks++;
            assert (cmdExp.size() != 0) else begin
                errors++;
                $error("[TB] FAIL cmd_unexpected observed=%h expected=none", cmd);
            end
            if (cmdExp.size() != 0) checkOutput("cmd_value", 64'(cmd), 64'(cmdExp.pop_front()));
        end
        if (rst === 1'b1 && in_isReady && in_canReceive) begin
            checks++;
            assert (inExp.size() != 0) else begin
                errors++;
                $error("[TB] FAIL in_unexpected observed=%h expected=none", in);
            end
            if (inExp.size() != 0) checkOutput("in_value", in, inExp.pop_front());
        end
        if (rst === 1'b1 && b_out_isReady && b_out_canReceive) begin
            checks++;
            assert (byteExp.size() != 0) else begin
                errors++;
                $error("[TB] FAIL b_out_unexpected observed=%h expected=none", b_out);
            end
            if (byteExp.size() != 0) checkOutput("b_out_value", 64'(b_out), 64'(byteExp.pop_front()));
            checkOutput("out_canReceive_during_shift", 64'(out_canReceive), 64'(0));
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        bit acc;
        int cnt;
        b_in = b;
        b_in_isReady = 1'b1;
        acc = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            acc = b_in_canReceive;
            tick();
            cnt++;
        end while (!acc && cnt < 500);
        b_in_isReady = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("[TB] FAIL b_in_timeout observed=%0d expected=1", acc);
        end
    endtask

    task automatic rxWord(input logic [63:0] w);
        inExp.push_back(w);
        for (int i = 0; i < 8; i++) applyStimulus(w[63-8*i -: 8]);
    endtask

    task automatic txWord(input logic [63:0] w);
        bit acc;
        int cnt;
        out = w;
        out_isReady = 1'b1;
        acc = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            acc = out_canReceive;
            tick();
            cnt++;
        end while (!acc && cnt < 500);
        out_isReady = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("[TB] FAIL out_timeout observed=%0d expected=1", acc);
        end
        if (acc) for (int i = 0; i < 8; i++) byteExp.push_back(w[63-8*i -: 8]);
    endtask

    task automatic waitDrain(input string tag);
        int cnt;
        cnt = 0;
        while ((cmdExp.size() + inExp.size() + byteExp.size()) != 0 && cnt < 3000) begin
            tick();
            cnt++;
        end
        tick();
        checks++;
        assert ((cmdExp.size() + inExp.size() + byteExp.size()) == 0) else begin
            errors++;
            $error("[TB] FAIL %s_drain observed=%0d pending expected=0", tag,
                   cmdExp.size() + inExp.size() + byteExp.size());
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd"}, 64'(cmd), 64'(0));
        checkOutput({tag, "_cmd_isReady"}, 64'(cmd_isReady), 64'(0));
        checkOutput({tag, "_in"}, in, 64'(0));
        checkOutput({tag, "_in_isReady"}, 64'(in_isReady), 64'(0));
        checkOutput({tag, "_b_out"}, 64'(b_out), 64'(0));
        checkOutput({tag, "_b_out_isReady"}, 64'(b_out_isReady), 64'(0));
        checkOutput({tag, "_b_in_canReceive"}, 64'(b_in_canReceive), 64'(1));
        checkOutput({tag, "_out_canReceive"}, 64'(out_canReceive), 64'(1));
    endtask

    initial begin
        logic [63:0] w1;
        logic [63:0] w2;

        // Reset values
        rst = 1'b0;
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b1;
        tick();

        // Stalled command 0x81
        $display("[TB] command stall");
        cmdExp.push_back(4'd1);
        cmd_canReceive = 1'b0;
        applyStimulus(8'h81);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_cmd_isReady", 64'(cmd_isReady), 64'(1));
            checkOutput("stall_cmd", 64'(cmd), 64'(1));
            checkOutput("stall_b_in_canReceive", 64'(b_in_canReceive), 64'(0));
            tick();
        end
        cmd_canReceive = 1'b1;
        tick();
        cmd_canReceive = 1'b0;
        checkOutput("post_cmd", 64'(cmd), 64'(0));
        checkOutput("post_cmd_isReady", 64'(cmd_isReady), 64'(0));
        checkOutput("post_cmd_hdr", 64'(b_in_canReceive), 64'(1));
        waitDrain("cmd_stall");

        // Two-word frame with in_isReady timing
        $display("[TB] two-word frame");
        w1 = 64'h0123456789ABCDEF;
        w2 = 64'hFEDCBA9876543210;
        in_canReceive = 1'b0;
        inExp.push_back(w1);
        inExp.push_back(w2);
        applyStimulus(8'h01);
        for (int i = 0; i < 8; i++) applyStimulus(w1[63-8*i -: 8]);
        checkOutput("w1_in_isReady", 64'(in_isReady), 64'(1));
        checkOutput("w1_in", in, w1);
        checkOutput("w1_b_in_blocked", 64'(b_in_canReceive), 64'(0));
        in_canReceive = 1'b1;
        tick();
        in_canReceive = 1'b0;
        checkOutput("w1_in_cleared", in, 64'(0));
        checkOutput("w1_in_isReady_cleared", 64'(in_isReady), 64'(0));
        checkOutput("w1_back_to_collect", 64'(b_in_canReceive), 64'(1));
        for (int i = 0; i < 8; i++) applyStimulus(w2[63-8*i -: 8]);
        checkOutput("w2_in_isReady", 64'(in_isReady), 64'(1));
        checkOutput("w2_in", in, w2);
        in_canReceive = 1'b1;
        tick();
        checkOutput("w2_back_to_hdr", 64'(b_in_canReceive), 64'(1));
        waitDrain("two_word");

        // TX word with toggling byte-link backpressure
        $display("[TB] tx toggle");
        b_out_canReceive = 1'b1;
        fork
            txWord(64'h0011223344556677);
            begin
                for (int c = 0; c < 40; c++) begin
                    tick();
                    b_out_canReceive = ~b_out_canReceive;
                    if (byteExp.size() != 0)
                        checkOutput("tx_out_canReceive_busy", 64'(out_canReceive), 64'(0));
                end
            end
        join
        b_out_canReceive = 1'b1;
        waitDrain("tx_toggle");
        checkOutput("tx_idle_out_canReceive", 64'(out_canReceive), 64'(1));
        checkOutput("tx_idle_b_out_isReady", 64'(b_out_isReady), 64'(0));

        // Full duplex: 4-word RX frame alongside 3 TX words
        $display("[TB] full duplex");
        in_canReceive = 1'b1;
        b_out_canReceive = 1'b1;
        fork
            begin
                applyStimulus(8'h03);
                for (int i = 0; i < 4; i++) rxWord({$urandom, $urandom});
            end
            begin
                for (int i = 0; i < 3; i++) txWord({$urandom, $urandom});
            end
        join
        waitDrain("duplex");

        // Null command is dropped, following command issued once
        $display("[TB] null command");
        cmd_canReceive = 1'b1;
        cmdExp.push_back(4'd2);
        applyStimulus(8'h80);
        checkOutput("null_cmd_isReady", 64'(cmd_isReady), 64'(0));
        checkOutput("null_stays_hdr", 64'(b_in_canReceive), 64'(1));
        applyStimulus(8'h82);
        waitDrain("null_cmd");
        cmd_canReceive = 1'b0;

        // Largest frame: header 0x7F carries 128 words
        $display("[TB] 128-word frame");
        in_canReceive = 1'b1;
        applyStimulus(8'h7F);
        for (int i = 0; i < 128; i++) rxWord({$urandom, $urandom});
        waitDrain("max_frame");
        checkOutput("max_frame_hdr", 64'(b_in_canReceive), 64'(1));

        // Reset in the middle of an RX word and a TX word
        $display("[TB] mid-operation reset");
        in_canReceive = 1'b0;
        b_out_canReceive = 1'b0;
        txWord(64'hA1A2A3A4A5A6A7A8);
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        rst = 1'b0;
        tick();
        inExp.delete();
        byteExp.delete();
        cmdExp.delete();
        checkResetValues("midreset");
        tick();
        checkResetValues("midreset_hold");
        rst = 1'b1;
        in_canReceive = 1'b1;
        b_out_canReceive = 1'b1;
        tick();
        applyStimulus(8'h00);
        rxWord(64'h1122334455667788);
        waitDrain("post_reset");
        repeat (20) tick();
        checkOutput("final_b_out_isReady", 64'(b_out_isReady), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
